pipe_addsub: RTL and testbench

- Parametrised, bit-sliced pipelined adder/subtractor; the successor of the single-cycle 32-bit hybrid adder.
- Splits the WIDTH-bit operation into STAGES slices. Each pipeline stage adds one slice and registers the carry into the next stage.
- Sits between the decode/operand-fetch stage and the ALU writeback path. Carries a tag (destination register index) alongside the data.
- Uses a valid/ready handshake on both input and output, so downstream stalls are supported.

---
 rtl/pipe_addsub_if.sv | 30 +++
 rtl/pipe_addsub.sv | 119 +++++++++++
 tb/tb_pipe_addsub.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle for pipe_addsub.
// Master drives operands and out_ready; slave returns results.
interface pipe_addsub_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic [TAG_W-1:0] tag_out;

  modport master (
    output in_valid, a, b, sub, tag_in, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, tag_out
  );

  modport slave (
    input  in_valid, a, b, sub, tag_in, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, tag_out
  );
endinterface

// File: rtl/pipe_addsub.sv
// Bit-sliced pipelined adder/subtractor: one WIDTH/STAGES slice per stage,
// carry registered between stages, global stall on output backpressure.
module pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 5
) (
  input logic          clk,
  input logic          rst,
  pipe_addsub_if.slave bus
);

  localparam int SW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;
  localparam int NR = (STAGES > 1) ? STAGES - 1 : 1;

  logic             adv;

  logic             rv [NR];
  logic             rc [NR];
  logic [WIDTH-1:0] rs [NR];
  logic [WIDTH-1:0] ra [NR];
  logic [WIDTH-1:0] rb [NR];
  logic [TAG_W-1:0] rt [NR];

  logic             vi [STAGES];
  logic             ci [STAGES];
  logic             co [STAGES];
  logic [WIDTH-1:0] si [STAGES];
  logic [WIDTH-1:0] ai [STAGES];
  logic [WIDTH-1:0] bi [STAGES];
  logic [WIDTH-1:0] ns [STAGES];
  logic [TAG_W-1:0] ti [STAGES];

  logic             ov_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic [TAG_W-1:0] tag_q;

  assign adv          = !ov_q || bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = ov_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.ovf      = ovf_q;
  assign bus.zero     = zero_q;
  assign bus.tag_out  = tag_q;

  for (genvar g = 0; g < STAGES; g++) begin : g_st
    localparam logic [WIDTH-1:0] M = WIDTH'({SW{1'b1}}) << (g * SW);
    logic [SW:0] add;

    if (g == 0) begin : g_in
      assign vi[g] = bus.in_valid;
      assign ci[g] = bus.sub;
      assign si[g] = '0;
      assign ai[g] = bus.a;
      assign bi[g] = bus.sub ? ~bus.b : bus.b;
      assign ti[g] = bus.tag_in;
    end else begin : g_rg
      assign vi[g] = rv[g-1];
      assign ci[g] = rc[g-1];
      assign si[g] = rs[g-1];
      assign ai[g] = ra[g-1];
      assign bi[g] = rb[g-1];
      assign ti[g] = rt[g-1];
    end

    assign add = {1'b0, ai[g][g*SW +: SW]}
               + {1'b0, bi[g][g*SW +: SW]}
               + {{SW{1'b0}}, ci[g]};
    assign co[g] = add[SW];
    assign ns[g] = (si[g] & ~M)
                 | (WIDTH'(add[SW-1:0]) << (g * SW));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NR; s++) begin
        rv[s] <= 1'b0;
        rc[s] <= 1'b0;
        rs[s] <= '0;
        ra[s] <= '0;
        rb[s] <= '0;
        rt[s] <= '0;
      end
      ov_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      tag_q  <= '0;
    end else if (adv) begin
      for (int s = 0; s < L; s++) begin
        rv[s] <= vi[s];
        if (vi[s]) begin
          rc[s] <= co[s];
          rs[s] <= ns[s];
          ra[s] <= ai[s];
          rb[s] <= bi[s];
          rt[s] <= ti[s];
        end
      end
      ov_q <= vi[L];
      if (vi[L]) begin
        sum_q  <= ns[L];
        cout_q <= co[L];
        // a^b^sum at the MSB recovers the carry into the MSB
        ovf_q  <= co[L] ^ ai[L][WIDTH-1]
                ^ bi[L][WIDTH-1] ^ ns[L][WIDTH-1];
        zero_q <= (ns[L] == '0);
        tag_q  <= ti[L];
      end
    end
  end

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub: directed steps plus random traffic
// scored against an arithmetic reference model.
module tb_pipe_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pipe_addsub_if bus ();
  pipe_addsub_if #(.WIDTH(8), .TAG_W(5)) b2 ();
  pipe_addsub_if #(.WIDTH(8), .TAG_W(5)) b1 ();

  pipe_addsub u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipe_addsub #(.WIDTH(8), .STAGES(2), .TAG_W(5)) u_s2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  pipe_addsub #(.WIDTH(8), .STAGES(1), .TAG_W(5)) u_s1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  typedef struct {
    logic [31:0] sum;
    logic        c;
    logic        v;
    logic        z;
    logic [4:0]  tag;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   last_acc;

  function automatic exp_t model(logic [31:0] a, logic [31:0] b,
                                 logic s, logic [4:0] t);
    exp_t   e;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = {32'b0, a};
    longint ub = {32'b0, b};
    longint r  = s ? sa - sb : sa + sb;
    e.sum = s ? a - b : a + b;
    e.c   = s ? (ua >= ub) : (ua + ub > 64'sd4294967295);
    e.v   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    e.z   = (e.sum == 32'd0);
    e.tag = t;
    return e;
  endfunction

  task automatic chk(string nm, logic [63:0] obs, logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, expv);
    end
  endtask

  task automatic tick();
    exp_t e;
    #1;
    last_acc = 1'b0;
    if (rst) begin
      q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("sum", bus.sum, e.sum);
          chk("cout", bus.cout, e.c);
          chk("ovf", bus.ovf, e.v);
          chk("zero", bus.zero, e.z);
          chk("tag", bus.tag_out, e.tag);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.a, bus.b, bus.sub, bus.tag_in));
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [31:0] a, logic [31:0] b,
                       logic s, logic [4:0] t);
    bus.a        = a;
    bus.b        = b;
    bus.sub      = s;
    bus.tag_in   = t;
    bus.in_valid = 1'b1;
  endtask

  task automatic drain(string nm);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 40 && q.size() > 0; n++) tick();
    chk(nm, q.size(), 0);
  endtask

  task automatic lat_op(logic [31:0] a, logic [31:0] b, logic s,
                        logic [4:0] t, int expl, string nm);
    int n;
    drive(a, b, s, t);
    tick();
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk(nm, n, expl);
    tick();
    chk({nm, "_after"}, bus.out_valid, 0);
  endtask

  task automatic sweep(logic [7:0] a, logic [7:0] b, logic [7:0] es,
                       logic ec, logic ev, logic ez, string nm);
    int          l2, l1;
    logic [10:0] f2, f1;
    b2.a = a; b2.b = b; b2.sub = 1'b0; b2.in_valid = 1'b1;
    b1.a = a; b1.b = b; b1.sub = 1'b0; b1.in_valid = 1'b1;
    @(posedge clk);
    #1;
    b2.in_valid = 1'b0;
    b1.in_valid = 1'b0;
    l2 = 0; l1 = 0; f2 = '0; f1 = '0;
    for (int n = 1; n <= 6; n++) begin
      if (b2.out_valid && l2 == 0) begin
        l2 = n;
        f2 = {b2.sum, b2.cout, b2.ovf, b2.zero};
      end
      if (b1.out_valid && l1 == 0) begin
        l1 = n;
        f1 = {b1.sum, b1.cout, b1.ovf, b1.zero};
      end
      @(posedge clk);
      #1;
    end
    chk({nm, "_s2_lat"}, l2, 2);
    chk({nm, "_s1_lat"}, l1, 1);
    chk({nm, "_s2_res"}, f2, {es, ec, ev, ez});
    chk({nm, "_s1_res"}, f1, {es, ec, ev, ez});
  endtask

  initial begin
    #400000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] fs;
    logic [4:0]  ft;
    logic [31:0] pick [4];
    int          k, st;

    pick[0] = 32'h0000_0000;
    pick[1] = 32'hFFFF_FFFF;
    pick[2] = 32'h8000_0000;
    pick[3] = 32'h7FFF_FFFF;

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
    bus.sub = 1'b0; bus.tag_in = '0; bus.out_ready = 1'b1;
    b2.in_valid = 1'b0; b2.a = '0; b2.b = '0;
    b2.sub = 1'b0; b2.tag_in = '0; b2.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.a = '0; b1.b = '0;
    b1.sub = 1'b0; b1.tag_in = '0; b1.out_ready = 1'b1;

    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_flags", {bus.cout, bus.ovf, bus.zero}, 0);
    chk("rst_tag", bus.tag_out, 0);
    chk("rst_in_ready", bus.in_ready, 1);

    lat_op(32'd2, 32'd3, 1'b0, 5'd7, 4, "basic_lat");

    drive(32'h5555_5555, 32'h2AAA_AAAA, 1'b0, 5'd1); tick();
    drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 5'd2); tick();
    drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 5'd3); tick();
    drain("alt_drain");

    drive(32'd7, 32'd5, 1'b1, 5'd4); tick();
    drive(32'd5, 32'd7, 1'b1, 5'd5); tick();
    drive(32'h8000_0000, 32'd1, 1'b1, 5'd6); tick();
    drain("sub_drain");

    bus.in_valid = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (!bus.in_valid || last_acc) begin
        if ($urandom_range(3) != 0) begin
          drive($urandom_range(3) == 0 ? pick[$urandom_range(3)] : $urandom,
                $urandom_range(3) == 0 ? pick[$urandom_range(3)] : $urandom,
                1'($urandom_range(1)), 5'($urandom));
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = ($urandom_range(3) != 0);
      tick();
    end
    drain("rand_drain");

    k = 0;
    st = 0;
    fs = '0;
    ft = '0;
    for (int n = 0; n < 40 && !(k == 4 && q.size() == 0); n++) begin
      if (k < 4) drive(32'd100 + k, 32'(k), 1'b0, 5'(k + 10));
      else bus.in_valid = 1'b0;
      if (bus.out_valid && st < 3) begin
        if (st == 0) begin
          fs = bus.sum;
          ft = bus.tag_out;
        end else begin
          chk("bp_sum_hold", bus.sum, fs);
          chk("bp_tag_hold", bus.tag_out, ft);
        end
        bus.out_ready = 1'b0;
        st++;
      end else begin
        bus.out_ready = 1'b1;
      end
      #1;
      if (!bus.out_ready) chk("bp_in_ready", bus.in_ready, 0);
      tick();
      if (last_acc) k++;
    end
    chk("bp_stalls", st, 3);
    chk("bp_first", {fs, ft}, {32'd100, 5'd10});
    drain("bp_drain");

    for (int i = 0; i < 3; i++) begin
      drive(32'd1000 + i, 32'd1, 1'b0, 5'(20 + i));
      tick();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_sum", bus.sum, 0);
    chk("mid_rst_flags", {bus.cout, bus.ovf, bus.zero}, 0);
    chk("mid_rst_tag", bus.tag_out, 0);
    for (int n = 0; n < 6; n++) begin
      tick();
      chk("mid_rst_no_stale", bus.out_valid, 0);
    end
    lat_op(32'd1, 32'd1, 1'b0, 5'd9, 4, "post_rst_lat");

    sweep(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, "w8_ff");
    sweep(8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, "w8_7f");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
